// File: rtl/fifo_wr_framer.sv
// fifo_wr_framer: write-side framing stage in front of the dual-clock FIFO.
// Accepts a valid/ready byte stream with end-of-frame marking, appends a
// one-word XOR checksum after each frame and drives the FIFO write port
// through a 2-entry skid buffer so upstream ready never depends on fifo_full.
// Optional statistics counters are enabled by defining FIFO_WR_FRAMER_STAT_EN.
module fifo_wr_framer #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] CSUM_INIT  = '0
) (
  input  logic                  wr_clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  input  logic                  fifo_full,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy
`ifdef FIFO_WR_FRAMER_STAT_EN
  ,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CSUM = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [DATA_WIDTH-1:0] acc_reg;

  logic                  head_reg;
  logic                  tail_reg;
  logic [1:0]            count_reg;
  logic [1:0]            count_next;
  logic [DATA_WIDTH-1:0] entry_data [2];

  logic                  head_valid;
  logic                  accept;
  logic                  pop;
  logic                  push;
  logic                  csum_push;
  logic [DATA_WIDTH-1:0] push_data;

  assign head_valid = (count_reg != 2'd0);
  assign accept     = s_valid && s_ready;
  // Writes are masked during reset so nothing stale leaks into the FIFO.
  assign pop        = head_valid && !fifo_full && !rst;
  assign push       = accept || csum_push;
  // Upstream words and the checksum never collide: s_ready is low in CSUM.
  assign push_data  = accept ? s_data : acc_reg;

  assign wr_en = pop;
  assign wdata = (head_valid && !rst) ? entry_data[head_reg] : '0;
  assign busy  = head_valid || (state_reg != IDLE);

  // FSM state register.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic: frame tracking and checksum insertion.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = s_last ? CSUM : DATA;
        end
      end
      DATA: begin
        if (accept && s_last) begin
          state_next = CSUM;
        end
      end
      CSUM: begin
        if (csum_push) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: ready is purely from registered state; the checksum is
  // pushed as soon as a buffer slot is free or is being freed this cycle.
  always_comb begin
    s_ready   = 1'b0;
    csum_push = 1'b0;
    if (!rst) begin
      s_ready   = (state_reg != CSUM) && (count_reg != 2'd2);
      csum_push = (state_reg == CSUM) && ((count_reg != 2'd2) || pop);
    end
  end

  // Checksum accumulator: seeded on the first word, reloaded after the push.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      acc_reg <= CSUM_INIT;
    end else if (accept) begin
      acc_reg <= ((state_reg == IDLE) ? CSUM_INIT : acc_reg) ^ s_data;
    end else if (csum_push) begin
      acc_reg <= CSUM_INIT;
    end
  end

  // Occupancy bookkeeping; a simultaneous push and pop leaves count unchanged.
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  // Buffer pointers and count; pointers wrap naturally as 1-bit values.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      head_reg  <= 1'b0;
      tail_reg  <= 1'b0;
      count_reg <= 2'd0;
    end else begin
      head_reg  <= head_reg ^ pop;
      tail_reg  <= tail_reg ^ push;
      count_reg <= count_next;
    end
  end

  // Buffer storage: one register per entry, written at the tail.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [DATA_WIDTH-1:0] data_reg;
      // Capture the pushed word when this entry is the tail.
      always_ff @(posedge wr_clk) begin
        if (push && (tail_reg == 1'(gi))) begin
          data_reg <= push_data;
        end
      end
      assign entry_data[gi] = data_reg;
    end
  endgenerate

`ifdef FIFO_WR_FRAMER_STAT_EN
  logic        entry_csum [2];
  logic [15:0] frame_cnt_reg;
  logic [15:0] stall_cnt_reg;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_tag
      logic tag_reg;
      // Remember which entries hold a checksum so frame completion is seen at pop.
      always_ff @(posedge wr_clk) begin
        if (push && (tail_reg == 1'(gi))) begin
          tag_reg <= csum_push;
        end
      end
      assign entry_csum[gi] = tag_reg;
    end
  endgenerate

  // Saturating frame and stall counters.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      frame_cnt_reg <= 16'd0;
      stall_cnt_reg <= 16'd0;
    end else begin
      if (pop && entry_csum[head_reg] && (frame_cnt_reg != 16'hFFFF)) begin
        frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end
      if (head_valid && fifo_full && (stall_cnt_reg != 16'hFFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
    end
  end

  assign frame_cnt = frame_cnt_reg;
  assign stall_cnt = stall_cnt_reg;
`else
  // Statistics disabled: no counters and no extra ports.
`endif

endmodule

// File: tb/tb_fifo_wr_framer.sv
// Directed testbench for fifo_wr_framer: hand-computed FIFO write sequences,
// handshake/latency spot checks, reset-mid-frame and (optionally) counters.
module tb_fifo_wr_framer;

  logic       wr_clk;
  logic       rst;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_ready;
  logic       fifo_full;
  logic       wr_en;
  logic [7:0] wdata;
  logic       busy;
`ifdef FIFO_WR_FRAMER_STAT_EN
  logic [15:0] frame_cnt;
  logic [15:0] stall_cnt;
`endif

  fifo_wr_framer #(.DATA_WIDTH(8), .CSUM_INIT(8'h00)) dut (
    .wr_clk    (wr_clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .fifo_full (fifo_full),
    .wr_en     (wr_en),
    .wdata     (wdata),
    .busy      (busy)
`ifdef FIFO_WR_FRAMER_STAT_EN
    ,
    .frame_cnt (frame_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] frame_buf [64];

  // Record every FIFO write, one line per write.
  always @(negedge wr_clk) begin
    if (wr_en) begin
      got_q.push_back(wdata);
      $display("[%0t] fifo write %02h", $time, wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge wr_clk);
    #1;
  endtask

  // Stream frame_buf[0..n-1]; optionally require acceptance every cycle.
  task automatic send_frame(input int n, input bit no_wait, input bit mark_last);
    bit acc;
    int waits;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = frame_buf[i];
      s_last  = mark_last && (i == n - 1);
      #1;
      if (no_wait && i > 0) check("stream_wr_en", wr_en, 1);
      waits = 0;
      do begin
        acc = s_ready;
        step();
        if (!acc) waits++;
      end while (!acc && waits < 200);
      if (!acc) check("accept_timeout", 0, 1);
      if (no_wait) check("no_wait", waits, 0);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    $display("[%0t] frame of %0d words sent", $time, n);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 500) begin
      step();
      k++;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic compare_q(input string tag);
    int n;
    check({tag, "_len"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check(tag, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int idx;
    int c;
    bit acc;
    logic [7:0] x;

    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; fifo_full = 1'b0;
    step();
    step();
    // Reset cycle outputs.
    check("rst_s_ready", s_ready, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wdata", wdata, 0);
    rst = 1'b0;
    #1;
    check("post_rst_busy", busy, 0);
    check("post_rst_s_ready", s_ready, 1);
    got_q.delete();

    // Single-word frame A5: data then checksum A5.
    frame_buf[0] = 8'hA5;
    send_frame(1, 1, 1);
    check("t1_lat_wr_en", wr_en, 1);
    check("t1_lat_wdata", wdata, 8'hA5);
    check("t1_csum_s_ready", s_ready, 0);
    step();
    check("t1_csum_wr_en", wr_en, 1);
    check("t1_csum_wdata", wdata, 8'hA5);
    check("t1_busy", busy, 1);
    step();
    check("t1_idle_busy", busy, 0);
    check("t1_idle_wr_en", wr_en, 0);
    exp_q = '{8'hA5, 8'hA5};
    compare_q("t1_order");

    // Four-word frame streamed back-to-back.
    frame_buf[0] = 8'h01; frame_buf[1] = 8'h02; frame_buf[2] = 8'h04; frame_buf[3] = 8'h08;
    send_frame(4, 1, 1);
    check("t2_csum_s_ready", s_ready, 0);
    step();
    check("t2_idle_s_ready", s_ready, 1);
    wait_idle();
    exp_q = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
    compare_q("t2_order");

    // fifo_full held for 10 cycles with a word already buffered.
    frame_buf[0] = 8'h11; frame_buf[1] = 8'h22; frame_buf[2] = 8'h33; frame_buf[3] = 8'h44;
    idx = 0;
    c = 0;
    while (idx < 4 && c < 200) begin
      fifo_full = (c >= 1 && c <= 10);
      s_valid   = 1'b1;
      s_data    = frame_buf[idx];
      s_last    = (idx == 3);
      #1;
      if (c >= 1 && c <= 10) check("t3_full_wr_en", wr_en, 0);
      if (c == 10) begin
        check("t3_full_s_ready", s_ready, 0);
        check("t3_full_accepted", idx, 2);
      end
      acc = s_ready;
      step();
      if (acc) idx++;
      c++;
    end
    s_valid = 1'b0; s_last = 1'b0; fifo_full = 1'b0;
    check("t3_all_accepted", idx, 4);
    wait_idle();
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    compare_q("t3_order");
`ifdef FIFO_WR_FRAMER_STAT_EN
    check("t3_stall_cnt", stall_cnt, 16'd10);
    check("t3_frame_cnt", frame_cnt, 16'd3);
`endif

    // 20-word frame: one push and one pop per cycle, count held at 1.
    x = 8'h00;
    for (int i = 0; i < 20; i++) begin
      frame_buf[i] = 8'(i * 7 + 3);
      x = x ^ frame_buf[i];
      exp_q.push_back(frame_buf[i]);
    end
    exp_q.push_back(x);
    send_frame(20, 1, 1);
    wait_idle();
    compare_q("t4_order");

    // Reset after 2 words of a 4-word frame held by fifo_full.
    fifo_full = 1'b1;
    frame_buf[0] = 8'hAA; frame_buf[1] = 8'hBB;
    send_frame(2, 0, 0);
    rst = 1'b1;
    #1;
    check("t5_rst_wr_en", wr_en, 0);
    check("t5_rst_wdata", wdata, 0);
    check("t5_rst_s_ready", s_ready, 0);
    step();
    rst = 1'b0;
    fifo_full = 1'b0;
    #1;
    check("t5_post_wr_en", wr_en, 0);
    check("t5_post_busy", busy, 0);
    check("t5_post_s_ready", s_ready, 1);
    frame_buf[0] = 8'h10;
    send_frame(1, 1, 1);
    wait_idle();
    exp_q = '{8'h10, 8'h10};
    compare_q("t5_order");
`ifdef FIFO_WR_FRAMER_STAT_EN
    check("t5_frame_cnt", frame_cnt, 16'd1);

    // Long stall: the stall counter saturates.
    fifo_full = 1'b1;
    frame_buf[0] = 8'h55;
    send_frame(1, 0, 1);
    for (int i = 0; i < 65540; i++) @(posedge wr_clk);
    #1;
    check("t6_stall_sat", stall_cnt, 16'hFFFF);
    fifo_full = 1'b0;
    wait_idle();
    exp_q = '{8'h55, 8'h55};
    compare_q("t6_order");
    check("t6_frame_cnt", frame_cnt, 16'd2);
    check("t6_stall_hold", stall_cnt, 16'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
